// File: rtl/arb_pkg.sv
// Types shared by the input arbiter and the result dispatcher.
// No logic here: FIFO entry metadata, source tag and dispatcher state encodings.
package arb_pkg;

  localparam int DW_DEF = 32;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_IDLE = 2'b00;

  typedef enum logic {
    SRC_SLV0 = 1'b0,
    SRC_SLV1 = 1'b1
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } disp_state_t;

  // Sideband fields carried alongside the payload of a result entry.
  typedef struct packed {
    src_t       src;
    mode_t      mode;
    logic [7:0] proc_val;
  } meta_t;

endpackage

// File: rtl/frame_counter.sv
// Per-destination word counter; wraps at FRAME_WORDS and pulses done_pulse for one cycle.
// Latency: done_pulse is registered, high the cycle after the final increment; no backpressure.
module frame_counter #(
  parameter int FRAME_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           inc,
  output logic [$clog2(FRAME_WORDS)-1:0] count,
  output logic                           done_pulse
);

  localparam int CNT_W = $clog2(FRAME_WORDS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             wrap;

  // Compare against FRAME_WORDS-1 so non-power-of-two frame sizes also wrap correctly.
  assign wrap = inc && (cnt_q == CNT_W'(FRAME_WORDS - 1));

  always_comb begin
    cnt_d  = cnt_q;
    done_d = wrap;
    if (wrap) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign count      = cnt_q;
  assign done_pulse = done_q;

endmodule

// File: rtl/result_dispatcher.sv
// Pops result FIFO entries and routes each to master port 0/1 by its stored source tag; 2 cycles pop->valid.
// Holds valid and payload stable until the selected port's ready; DISP_MODE_DROP_EN discards mode-00 entries.
module result_dispatcher
  import arb_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int FRAME_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  output logic          fifo_rd_en,
  input  logic [DW-1:0] fifo_data,
  input  logic [1:0]    fifo_mode,
  input  logic [7:0]    fifo_proc_val,
  input  logic          fifo_src,
  output logic          mst0_valid,
  input  logic          mst0_ready,
  output logic [DW-1:0] mst0_data,
  output logic [1:0]    mst0_mode,
  output logic [7:0]    mst0_proc_val,
  output logic          mst1_valid,
  input  logic          mst1_ready,
  output logic [DW-1:0] mst1_data,
  output logic [1:0]    mst1_mode,
  output logic [7:0]    mst1_proc_val,
  output logic          mstr0_cmplt,
  output logic          mstr1_cmplt
);

  localparam int CNT_W = $clog2(FRAME_WORDS);

  disp_state_t   state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  meta_t         meta_q, meta_d;
  logic          pop;
  logic          sel0, sel1, hs;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic          unused_cnt;

  assign sel0 = (state_q == ST_SEND) && (meta_q.src == SRC_SLV0);
  assign sel1 = (state_q == ST_SEND) && (meta_q.src == SRC_SLV1);
  assign hs   = (sel0 && mst0_ready) || (sel1 && mst1_ready);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    meta_d  = meta_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        data_d  = fifo_data;
        meta_d  = {src_t'(fifo_src), fifo_mode, fifo_proc_val};
        state_d = ST_SEND;
`ifdef DISP_MODE_DROP_EN
        if (fifo_mode == MODE_IDLE) begin
          state_d = ST_IDLE;
        end
`endif
      end
      ST_SEND: begin
        if (hs) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      meta_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      meta_q  <= meta_d;
    end
  end

  // Gate with rst_n so a non-empty FIFO is never popped while reset is held.
  assign fifo_rd_en = pop && rst_n;

  assign mst0_valid    = sel0;
  assign mst0_data     = sel0 ? data_q        : '0;
  assign mst0_mode     = sel0 ? meta_q.mode   : '0;
  assign mst0_proc_val = sel0 ? meta_q.proc_val : '0;
  assign mst1_valid    = sel1;
  assign mst1_data     = sel1 ? data_q        : '0;
  assign mst1_mode     = sel1 ? meta_q.mode   : '0;
  assign mst1_proc_val = sel1 ? meta_q.proc_val : '0;

  frame_counter #(.FRAME_WORDS(FRAME_WORDS)) u_cnt0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (sel0 && mst0_ready),
    .count      (cnt0),
    .done_pulse (mstr0_cmplt)
  );

  frame_counter #(.FRAME_WORDS(FRAME_WORDS)) u_cnt1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (sel1 && mst1_ready),
    .count      (cnt1),
    .done_pulse (mstr1_cmplt)
  );

  assign unused_cnt = ^{cnt0, cnt1};

endmodule

// File: tb/tb_result_dispatcher.sv
// Directed bench for result_dispatcher with FRAME_WORDS=4 and a behavioural result FIFO.
module tb_result_dispatcher;
  localparam int DW = 32;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_empty, fifo_rd_en;
  logic [DW-1:0] fifo_data = '0;
  logic [1:0]    fifo_mode = '0;
  logic [7:0]    fifo_proc_val = '0;
  logic          fifo_src = 1'b0;
  logic          mst0_valid, mst0_ready, mst1_valid, mst1_ready;
  logic [DW-1:0] mst0_data, mst1_data;
  logic [1:0]    mst0_mode, mst1_mode;
  logic [7:0]    mst0_proc_val, mst1_proc_val;
  logic          mstr0_cmplt, mstr1_cmplt;

  int vectors = 0;
  int miscompares = 0;

  logic [42:0] mem [0:63];
  int push_cnt = 0;
  int pop_cnt = 0;
  bit underflow = 1'b0;

  result_dispatcher #(.DW(DW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .fifo_mode(fifo_mode),
    .fifo_proc_val(fifo_proc_val), .fifo_src(fifo_src),
    .mst0_valid(mst0_valid), .mst0_ready(mst0_ready), .mst0_data(mst0_data),
    .mst0_mode(mst0_mode), .mst0_proc_val(mst0_proc_val),
    .mst1_valid(mst1_valid), .mst1_ready(mst1_ready), .mst1_data(mst1_data),
    .mst1_mode(mst1_mode), .mst1_proc_val(mst1_proc_val),
    .mstr0_cmplt(mstr0_cmplt), .mstr1_cmplt(mstr1_cmplt)
  );

  always #5 clk = ~clk;

  // Result FIFO model: read data appears the cycle after the pop strobe.
  assign fifo_empty = (push_cnt == pop_cnt);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (push_cnt == pop_cnt) begin
        underflow <= 1'b1;
      end else begin
        {fifo_src, fifo_mode, fifo_proc_val, fifo_data} <= mem[pop_cnt];
        pop_cnt <= pop_cnt + 1;
      end
    end
  end

  task automatic push(input logic src, input logic [1:0] mode, input logic [7:0] pv,
                      input logic [31:0] data);
    mem[push_cnt] = {src, mode, pv, data};
    push_cnt = push_cnt + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(input string tag, input logic port);
    int n;
    n = 0;
    while (!(port ? mst1_valid : mst0_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(port ? mst1_valid : mst0_valid), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] cnt(input logic port);
    return port ? 32'(dut.u_cnt1.count) : 32'(dut.u_cnt0.count);
  endfunction

  int seen;

  initial begin
    rst_n = 1'b0;
    mst0_ready = 1'b1;
    mst1_ready = 1'b1;

    // Reset held with a non-empty FIFO
    push(1'b0, 2'd1, 8'h1A, 32'hA);
    push(1'b1, 2'd2, 8'h1B, 32'hB);
    push(1'b0, 2'd3, 8'h1C, 32'hC);
    repeat (3) @(negedge clk);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_v0", 32'(mst0_valid), 32'd0);
    check("rst_v1", 32'(mst1_valid), 32'd0);
    check("rst_d0", mst0_data, 32'd0);
    check("rst_d1", mst1_data, 32'd0);
    check("rst_m0", 32'(mst0_mode), 32'd0);
    check("rst_pv1", 32'(mst1_proc_val), 32'd0);
    check("rst_c0", 32'(mstr0_cmplt), 32'd0);
    check("rst_c1", 32'(mstr1_cmplt), 32'd0);
    check("rst_pops", 32'(pop_cnt), 32'd0);

    // Routing with readies tied high
    rst_n = 1'b1;
    #1 check("rt_first_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    check("rt_fetch_rd", 32'(fifo_rd_en), 32'd0);
    check("rt_fetch_v0", 32'(mst0_valid), 32'd0);
    @(negedge clk);
    check("rt_A_v0", 32'(mst0_valid), 32'd1);
    check("rt_A_d0", mst0_data, 32'hA);
    check("rt_A_m0", 32'(mst0_mode), 32'd1);
    check("rt_A_pv0", 32'(mst0_proc_val), 32'h1A);
    check("rt_A_v1", 32'(mst1_valid), 32'd0);
    check("rt_A_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    check("rt_gap_v0", 32'(mst0_valid), 32'd0);
    check("rt_gap_v1", 32'(mst1_valid), 32'd0);
    @(negedge clk);
    check("rt_B_v1", 32'(mst1_valid), 32'd1);
    check("rt_B_d1", mst1_data, 32'hB);
    check("rt_B_m1", 32'(mst1_mode), 32'd2);
    check("rt_B_v0", 32'(mst0_valid), 32'd0);
    check("rt_B_d0", mst0_data, 32'd0);
    check("rt_B_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("rt_C_v0", 32'(mst0_valid), 32'd1);
    check("rt_C_d0", mst0_data, 32'hC);
    check("rt_C_rd", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    check("rt_pops", 32'(pop_cnt), 32'd3);
    check("rt_cnt0", cnt(1'b0), 32'd2);
    check("rt_cnt1", cnt(1'b1), 32'd1);
    check("rt_idle_v0", 32'(mst0_valid), 32'd0);

    // Backpressure on port 0 with another entry waiting
    do_reset();
    mst0_ready = 1'b0;
    mst1_ready = 1'b1;
    push(1'b0, 2'd1, 8'h5A, 32'hA);
    push(1'b1, 2'd3, 8'h77, 32'hD);
    #1 check("bp_first_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_v0", 32'(mst0_valid), 32'd1);
      check("bp_d0", mst0_data, 32'hA);
      check("bp_pv0", 32'(mst0_proc_val), 32'h5A);
      check("bp_rd", 32'(fifo_rd_en), 32'd0);
      check("bp_v1", 32'(mst1_valid), 32'd0);
    end
    mst0_ready = 1'b1;
    #1 check("bp_hs_rd", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    check("bp_cnt0", cnt(1'b0), 32'd1);
    check("bp_after_v0", 32'(mst0_valid), 32'd0);
    wait_vld("bp_D_vld", 1'b1);
    check("bp_D_d1", mst1_data, 32'hD);
    check("bp_D_m1", 32'(mst1_mode), 32'd3);
    check("bp_D_pv1", 32'(mst1_proc_val), 32'h77);
    @(negedge clk);
    check("bp_drained", 32'(pop_cnt), 32'(push_cnt));

    // Frame completion on port 1
    do_reset();
    for (int i = 0; i < FW; i++) push(1'b1, 2'd1, 8'h00, 32'h100 + 32'(i));
    for (int w = 0; w < FW; w++) begin
      wait_vld("frm_vld", 1'b1);
      check("frm_d1", mst1_data, 32'h100 + 32'(w));
      check("frm_c1_early", 32'(mstr1_cmplt), 32'd0);
      @(negedge clk);
    end
    check("frm_c1_pulse", 32'(mstr1_cmplt), 32'd1);
    check("frm_c0_quiet", 32'(mstr0_cmplt), 32'd0);
    check("frm_cnt1_wrap", cnt(1'b1), 32'd0);
    @(negedge clk);
    check("frm_c1_off", 32'(mstr1_cmplt), 32'd0);
    push(1'b1, 2'd1, 8'h00, 32'h104);
    wait_vld("frm5_vld", 1'b1);
    @(negedge clk);
    check("frm5_c1", 32'(mstr1_cmplt), 32'd0);
    check("frm5_cnt1", cnt(1'b1), 32'd1);

    // Reset while port 1 is holding a word
    mst1_ready = 1'b0;
    push(1'b1, 2'd2, 8'h3C, 32'h77);
    wait_vld("rm_vld", 1'b1);
    check("rm_d1", mst1_data, 32'h77);
    push(1'b1, 2'd1, 8'h4D, 32'h88);
    #2 rst_n = 1'b0;
    #1;
    check("rm_v1_async", 32'(mst1_valid), 32'd0);
    check("rm_d1_async", mst1_data, 32'd0);
    check("rm_cnt1", cnt(1'b1), 32'd0);
    check("rm_rd", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rm_rel_rd", 32'(fifo_rd_en), 32'd1);
    mst1_ready = 1'b1;
    wait_vld("rm_next_vld", 1'b1);
    check("rm_next_d1", mst1_data, 32'h88);
    check("rm_next_m1", 32'(mst1_mode), 32'd1);
    @(negedge clk);
    check("rm_cnt1_restart", cnt(1'b1), 32'd1);
    check("rm_drained", 32'(pop_cnt), 32'(push_cnt));

    // Mode-00 entry: dropped only when the feature is built in
    seen = 0;
    push(1'b0, 2'd0, 8'h99, 32'h55);
    repeat (8) begin
      @(negedge clk);
      if (mst0_valid) begin
        seen++;
        check("drop_d0", mst0_data, 32'h55);
      end
    end
`ifdef DISP_MODE_DROP_EN
    check("drop_seen", 32'(seen), 32'd0);
    check("drop_cnt0", cnt(1'b0), 32'd0);
`else
    check("drop_seen", 32'(seen), 32'd1);
    check("drop_cnt0", cnt(1'b0), 32'd1);
`endif
    check("drop_popped", 32'(pop_cnt), 32'(push_cnt));
    check("no_underflow", 32'(underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
